// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache with a two-word block refill over
// the iREN/iwait bus handshake, plus saturating hit/miss statistics.
module icache_controller #(
    parameter int SETS   = 16,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              halt,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IW = $clog2(SETS);
    localparam int TW = WORD_W - IW - 3;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, FETCH0, FETCH1} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [TW-1:0]     w_tag;
    logic [IW-1:0]     w_idx;
    logic              w_sel;
    logic              w_unused_ok;

    logic [TW-1:0]     r_miss_tag;
    logic [IW-1:0]     r_miss_idx;
    logic [CNT_W-1:0]  r_hit_count;
    logic [CNT_W-1:0]  r_miss_count;

    logic [SETS-1:0]   w_valid;
    logic [TW-1:0]     w_tag_arr   [SETS];
    logic [WORD_W-1:0] w_word0_arr [SETS];
    logic [WORD_W-1:0] w_word1_arr [SETS];

    logic              w_lookup;
    logic              w_hit;
    logic              w_start_miss;
    logic              w_fill0;
    logic              w_fill_done;

    assign w_tag       = imemaddr[WORD_W-1:IW+3];
    assign w_idx       = imemaddr[IW+2:3];
    assign w_sel       = imemaddr[2];
    assign w_unused_ok = ^imemaddr[1:0];

    assign w_lookup = imemREN & w_valid[w_idx] & (w_tag_arr[w_idx] == w_tag);
    // Lookups are only honoured while no refill is in flight.
    assign w_hit    = (r_state == IDLE) & w_lookup;

    assign ihit       = w_hit;
    assign imemload   = w_hit ? (w_sel ? w_word1_arr[w_idx] : w_word0_arr[w_idx]) : '0;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    always_comb begin
        w_state_next = r_state;
        w_start_miss = 1'b0;
        w_fill0      = 1'b0;
        w_fill_done  = 1'b0;
        iREN         = 1'b0;
        iaddr        = '0;
        case (r_state)
            IDLE: begin
                if (imemREN && !w_lookup && !halt) begin
                    w_start_miss = 1'b1;
                    w_state_next = FETCH0;
                end
            end
            FETCH0: begin
                iREN  = 1'b1;
                iaddr = {r_miss_tag, r_miss_idx, 1'b0, 2'b00};
                if (!iwait) begin
                    w_fill0      = 1'b1;
                    w_state_next = FETCH1;
                end
            end
            FETCH1: begin
                iREN  = 1'b1;
                iaddr = {r_miss_tag, r_miss_idx, 1'b1, 2'b00};
                if (!iwait) begin
                    w_fill_done  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_miss_tag   <= '0;
            r_miss_idx   <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_miss) begin
                r_miss_tag <= w_tag;
                r_miss_idx <= w_idx;
            end
            if (w_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + CNT_ONE;
            end
            if (w_start_miss && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + CNT_ONE;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_set
            localparam logic [IW-1:0] SET_ID = IW'(gi);

            logic              r_valid;
            logic [TW-1:0]     r_tag;
            logic [WORD_W-1:0] r_word0;
            logic [WORD_W-1:0] r_word1;
            logic              w_fill_sel;

            assign w_fill_sel = (r_miss_idx == SET_ID);

            // Invalidate on miss start so a half-written block can never hit.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_valid <= 1'b0;
                end else if (w_start_miss && (w_idx == SET_ID)) begin
                    r_valid <= 1'b0;
                end else if (w_fill_done && w_fill_sel) begin
                    r_valid <= 1'b1;
                end
            end

            always_ff @(posedge CLK) begin
                if (w_fill0 && w_fill_sel) begin
                    r_word0 <= iload;
                end
                if (w_fill_done && w_fill_sel) begin
                    r_word1 <= iload;
                    r_tag   <= r_miss_tag;
                end
            end

            assign w_valid[gi]     = r_valid;
            assign w_tag_arr[gi]   = r_tag;
            assign w_word0_arr[gi] = r_word0;
            assign w_word1_arr[gi] = r_word1;
        end
    endgenerate

endmodule

// File: tb/tb_icache_controller.sv
// Bench for icache_controller: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a set-array cache model.
module tb_icache_controller;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        halt = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    icache_controller #(.SETS(16), .WORD_W(32), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt), .imemREN(imemREN),
        .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h40) return 32'hAAAA_0001;
        if (a == 32'h44) return 32'hAAAA_0002;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus slave: each requested word is held off for a configurable number of waits.
    int bus_wait  = 0;
    bit rand_wait = 1'b0;
    int wait_left = 0;
    bit ren_prev  = 1'b0;
    bit acc_prev  = 1'b0;

    always @(negedge CLK) begin
        ren_prev = iREN;
        acc_prev = iREN && !iwait;
    end

    always begin
        @(posedge CLK);
        #2;
        if (iREN) begin
            if (!ren_prev || acc_prev)
                wait_left = rand_wait ? int'($urandom_range(0, 2)) : bus_wait;
            if (wait_left > 0) begin
                iwait = 1'b1;
                iload = $urandom;
                wait_left--;
            end else begin
                iwait = 1'b0;
                iload = mem(iaddr);
            end
        end else begin
            iwait = 1'b1;
            iload = $urandom;
        end
    end

    // Reference model: a set array plus "refill in progress, n words received".
    bit          m_valid [16];
    logic [24:0] m_tag   [16];
    logic [31:0] m_w0    [16];
    logic [31:0] m_w1    [16];
    bit          m_fill;
    int          m_words;
    logic [31:0] m_base;
    logic [31:0] m_buf;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    function automatic bit m_would_hit(input logic [31:0] a);
        return !m_fill && imemREN && m_valid[a[6:3]] && (m_tag[a[6:3]] == a[31:7]);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
            m_fill = 1'b0; m_words = 0; m_base = 32'h0; m_buf = 32'h0;
            m_hits = 32'h0; m_misses = 32'h0;
        end else if (!m_fill) begin
            if (m_would_hit(imemaddr)) begin
                if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
            end else if (imemREN && !halt) begin
                m_fill = 1'b1; m_words = 0;
                m_base = {imemaddr[31:3], 3'b000};
                m_valid[imemaddr[6:3]] = 1'b0;
                if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
            end
        end else if (!iwait) begin
            if (m_words == 0) begin
                m_buf = iload; m_words = 1;
            end else begin
                m_w0[m_base[6:3]] = m_buf;
                m_w1[m_base[6:3]] = iload;
                m_tag[m_base[6:3]] = m_base[31:7];
                m_valid[m_base[6:3]] = 1'b1;
                m_fill = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        logic        e_hit;
        logic [31:0] e_load;
        e_hit  = m_would_hit(imemaddr);
        e_load = e_hit ? (imemaddr[2] ? m_w1[imemaddr[6:3]] : m_w0[imemaddr[6:3]]) : 32'h0;
        chk("ihit", {31'h0, ihit}, {31'h0, e_hit});
        chk("imemload", imemload, e_load);
        chk("iREN", {31'h0, iREN}, {31'h0, m_fill});
        chk("iaddr", iaddr, m_fill ? (m_base | (32'(m_words) << 2)) : 32'h0);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
    end

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_hit(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            next();
            #3;
            if (ihit === 1'b1) begin
                n_checks++;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: ihit not seen within %0d cycles", name, budget);
    endtask

    logic [31:0] mc, hc;

    initial begin
        next();
        next();
        chk("rst_ihit", {31'h0, ihit}, 32'h0);
        chk("rst_iREN", {31'h0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_hits", hit_count, 32'h0);
        chk("rst_misses", miss_count, 32'h0);

        // First miss and refill of block 0x40
        next(); nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; #3;
        chk("t1_miss_ihit", {31'h0, ihit}, 32'h0);
        chk("t1_idle_iREN", {31'h0, iREN}, 32'h0);
        next(); #3;
        chk("t1_f0_iREN", {31'h0, iREN}, 32'h1);
        chk("t1_f0_iaddr", iaddr, 32'h40);
        next(); #3;
        chk("t1_f1_iaddr", iaddr, 32'h44);
        next(); #3;
        chk("t1_hit", {31'h0, ihit}, 32'h1);
        chk("t1_load0", imemload, 32'hAAAA_0001);
        chk("t1_misses", miss_count, 32'h1);
        next(); imemaddr = 32'h44; #3;
        chk("t1_load1", imemload, 32'hAAAA_0002);

        // Conflict on index 8
        next(); imemaddr = 32'hC0; #3;
        chk("t2_conf_miss", {31'h0, ihit}, 32'h0);
        wait_hit("t2_fill_c0", 20);
        next(); imemaddr = 32'h40; #3;
        chk("t2_evicted", {31'h0, ihit}, 32'h0);
        wait_hit("t2_refill_40", 20);
        chk("t2_misses", miss_count, 32'h3);

        // Bus waits of 5 per word, address moves during the second word
        next(); imemaddr = 32'h200; #3;
        wait_hit("t3_fill_200", 20);
        bus_wait = 5;
        next(); imemaddr = 32'h100; #3;
        chk("t3_miss_100", {31'h0, ihit}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            next(); #3;
            chk("t3_w0_iREN", {31'h0, iREN}, 32'h1);
            chk("t3_w0_iaddr", iaddr, 32'h100);
        end
        for (int k = 0; k < 6; k++) begin
            next();
            if (k == 0) imemaddr = 32'h200;
            #3;
            chk("t3_w1_iaddr", iaddr, 32'h104);
            chk("t3_w1_ihit", {31'h0, ihit}, 32'h0);
        end
        next(); #3;
        chk("t3_200_misses", {31'h0, ihit}, 32'h0);
        imemaddr = 32'h104; #1;
        chk("t3_104_hits", {31'h0, ihit}, 32'h1);
        chk("t3_104_data", imemload, mem(32'h104));
        bus_wait = 0;

        // halt blocks new fills but not hits
        next(); halt = 1'b1; imemaddr = 32'h300; mc = miss_count; #3;
        for (int k = 0; k < 3; k++) begin
            next(); #3;
            chk("t4_halt_iREN", {31'h0, iREN}, 32'h0);
            chk("t4_halt_misses", miss_count, mc);
        end
        next(); imemaddr = 32'h100; #3;
        chk("t4_halt_hit", {31'h0, ihit}, 32'h1);
        hc = hit_count;
        next(); #3;
        chk("t4_halt_hitcnt", hit_count, hc + 32'h1);
        halt = 1'b0;

        // Reset during the second word of a fill
        next(); imemaddr = 32'h400; #3;
        next();
        next();
        chk("t5_f1_iREN", {31'h0, iREN}, 32'h1);
        chk("t5_f1_iaddr", iaddr, 32'h404);
        nRST = 1'b0; #1;
        chk("t5_async_iREN", {31'h0, iREN}, 32'h0);
        chk("t5_hits0", hit_count, 32'h0);
        chk("t5_misses0", miss_count, 32'h0);
        next();
        next(); nRST = 1'b1; imemaddr = 32'h40; #3;
        chk("t5_cold_miss", {31'h0, ihit}, 32'h0);
        wait_hit("t5_refill", 20);
        chk("t5_refill_data", imemload, 32'hAAAA_0001);

        // Randomized traffic over a few tags per index
        rand_wait = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            next();
            if ($urandom_range(0, 399) == 0) begin
                nRST = 1'b0;
                next();
                nRST = 1'b1;
            end
            imemREN  = ($urandom_range(0, 9) < 8);
            halt     = ($urandom_range(0, 19) == 0);
            imemaddr = {25'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)), 2'b00};
        end
        next();
        next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
